// File: rtl/bootld_pkg.sv
// Purpose: shared types and constants for the boot RAM byte-stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bootld_pkg;

    // Loader FSM states. WR and VFY are only reached when readback is built in.
    typedef enum logic [3:0] {
        IDLE, AH, AL, LH, LL, DL, DH, WR, VFY, CS, DONE, ERR
    } state_t;

    localparam logic [7:0] SYNC_DEF = 8'hA5;

    // Byte offsets of the frame fields; data pairs start at FRM_DATA, CSUM follows the last pair.
    localparam int FRM_SYNC   = 0;
    localparam int FRM_ADDR_H = 1;
    localparam int FRM_ADDR_L = 2;
    localparam int FRM_LEN_H  = 3;
    localparam int FRM_LEN_L  = 4;
    localparam int FRM_DATA   = 5;

    // Running 8-bit frame checksum.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/bootram_loader.sv
// Purpose: parses SYNC/addr/len/data/csum byte frames and writes 16-bit words into the NEO430 boot RAM port B.
// Latency: write pulse one cycle after the high data byte is accepted; done/err one cycle after CSUM.
// Backpressure: s_ready high while parsing; low in DONE/ERR, while clear is high, and in the WR/VFY stall (readback builds).
//
// Ports: clk/reset (async, active high); s_data/s_valid/s_ready byte stream in;
//   mem_we/mem_addr/mem_wdata/mem_rdata RAM port B; cpu_hold, done, err status out; clear returns to IDLE.
// Build option: define BOOTLD_READBACK_EN to read each written word back and flag a mismatch as err.
module bootram_loader
    import bootld_pkg::*;
#(
    parameter int         ADDR = 11,
    parameter int         DATA = 16,        // must stay 16: words are assembled from two bytes
    parameter logic [7:0] SYNC = SYNC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_wdata,
    input  logic [DATA-1:0] mem_rdata,
    output logic            cpu_hold,
    output logic            done,
    output logic            err,
    input  logic            clear
);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  addr_h;
    logic [7:0]  len_h;
    logic [7:0]  data_lo;
    logic [15:0] words_left;
    logic [7:0]  sum;
    logic [7:0]  sum_nxt;
    logic [15:0] addr_full;
    logic        accept;

    assign sum_nxt   = csum_add(sum, s_data);
    assign addr_full = {addr_h, s_data};
    assign accept    = s_valid & s_ready;

`ifdef BOOTLD_READBACK_EN
    logic rb_bad;
    // Read data in VFY belongs to the address presented during the WR pulse.
    assign rb_bad = (mem_rdata != mem_wdata);
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        if (clear) begin
            // clear wins over a byte in the same cycle; that byte stays unconsumed
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    s_ready = 1'b1;
                    if (s_valid && s_data == SYNC) state_nxt = AH;
                end
                AH: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = AL;
                end
                AL: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = LH;
                end
                LH: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = LL;
                end
                LL: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = ({len_h, s_data} == 16'd0) ? CS : DL;
                end
                DL: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = DH;
                end
                DH: begin
                    s_ready = 1'b1;
`ifdef BOOTLD_READBACK_EN
                    if (s_valid) state_nxt = WR;
`else
                    // write pulse overlaps the next byte, so no stall here
                    if (s_valid) state_nxt = (words_left == 16'd1) ? CS : DL;
`endif
                end
`ifdef BOOTLD_READBACK_EN
                WR:  state_nxt = VFY;
                VFY: state_nxt = rb_bad ? ERR : ((words_left == 16'd0) ? CS : DL);
`endif
                CS: begin
                    s_ready = 1'b1;
                    if (s_valid) state_nxt = (sum_nxt == 8'd0) ? DONE : ERR;
                end
                DONE:    state_nxt = DONE;
                ERR:     state_nxt = ERR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_h     <= '0;
            len_h      <= '0;
            data_lo    <= '0;
            words_left <= '0;
            sum        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state  <= state_nxt;
            mem_we <= 1'b0;
            // address advances on the edge that ends the write pulse
            if (mem_we) mem_addr <= mem_addr + 1'b1;
            if (clear) begin
                done <= 1'b0;
                err  <= 1'b0;
            end else if (accept) begin
                sum <= (state == IDLE) ? 8'd0 : sum_nxt;
                case (state)
                    IDLE: if (s_data == SYNC) cpu_hold <= 1'b1;
                    AH:   addr_h <= s_data;
                    AL:   mem_addr <= addr_full[ADDR-1:0];
                    LH:   len_h <= s_data;
                    LL:   words_left <= {len_h, s_data};
                    DL:   data_lo <= s_data;
                    DH: begin
                        mem_we     <= 1'b1;
                        mem_wdata  <= {s_data, data_lo};
                        words_left <= words_left - 16'd1;
                    end
                    CS: begin
                        if (sum_nxt == 8'd0) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef BOOTLD_READBACK_EN
            else if (state == VFY && rb_bad) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bootram_loader.sv
module tb_bootram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic        clear;

    bootram_loader dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .clear(clear)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Simple synchronous RAM, write-first, with an optional bit-0 corruption at word 0x010.
    logic [15:0] ram [0:2047];
    bit          flip_en = 1'b0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_we ? mem_wdata : ram[mem_addr]) ^ {15'd0, (flip_en && mem_addr == 11'h010)};
    end

    // Write log captured away from the clock edge.
    typedef struct { int a; int d; } wr_t;
    wr_t  wlog [$];
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wlog.push_back('{int'(mem_addr), int'(mem_wdata)});
            chk("we_single_pulse", {31'd0, prev_we}, 32'd0);
        end
        prev_we = mem_we;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit gaps = 1'b0;

    task automatic send(input logic [7:0] b, input int budget, output bit acc);
        acc     = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        s_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] b);
        bit acc;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(b, 50, acc);
        if (!acc) begin
            total++;
            $display("FAIL byte_accept: byte %0h not taken within 50 cycles", b);
        end
    endtask

    logic [15:0] words [$];
    logic [7:0]  junk  [$];

    // Sends junk, then a complete frame built from addr, words and a checksum offset.
    task automatic send_frame(input logic [15:0] a, input logic [7:0] dlt);
        logic [7:0] sum;
        logic [7:0] hdr [4];
        int n;
        n = words.size();
        wlog.delete();
        foreach (junk[i]) send_ok(junk[i]);
        send_ok(8'hA5);
        hdr[0] = a[15:8]; hdr[1] = a[7:0]; hdr[2] = n[15:8]; hdr[3] = n[7:0];
        sum = 8'd0;
        for (int i = 0; i < 4; i++) begin send_ok(hdr[i]); sum += hdr[i]; end
        foreach (words[i]) begin
            send_ok(words[i][7:0]);  sum += words[i][7:0];
            send_ok(words[i][15:8]); sum += words[i][15:8];
        end
        send_ok(8'(-sum) + dlt);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Reference: word i lands at (a + i) mod 2^11, in order.
    task automatic check_frame(input string tag, input logic [15:0] a, input bit exp_done);
        chk({tag, "_nwrites"}, wlog.size(), words.size());
        for (int i = 0; i < wlog.size() && i < words.size(); i++) begin
            chk({tag, "_addr"}, wlog[i].a, (int'(a) + i) % 2048);
            chk({tag, "_data"}, wlog[i].d, int'(words[i]));
        end
        @(negedge clk);
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_err"}, err, !exp_done);
        chk({tag, "_hold"}, cpu_hold, !exp_done);
        chk({tag, "_ready_low"}, s_ready, 1'b0);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1; s_data = 8'hA5; s_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; s_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a; int n; logic [7:0] dlt; int junk; logic [15:0] w0;
        bit exp_done; bit exp_err; bit exp_hold; int exp_first; int exp_last;
    } vec_t;
    vec_t vt [5];

    initial begin
        bit acc;
        vt[0] = '{16'h0010, 2, 8'd0, 0, 16'h1234, 1'b1, 1'b0, 1'b0, 'h010, 'h011};
        vt[1] = '{16'h0010, 2, 8'd1, 0, 16'h1234, 1'b0, 1'b1, 1'b1, 'h010, 'h011};
        vt[2] = '{16'h07FF, 2, 8'd0, 0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 'h7FF, 'h000};
        vt[3] = '{16'h0123, 0, 8'd0, 2, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0};
        vt[4] = '{16'hF805, 3, 8'd0, 0, 16'h0001, 1'b1, 1'b0, 1'b0, 'h005, 'h007};

        reset = 1'b1; s_data = 8'h00; s_valid = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 11'd0);
        chk("rst_wdata", mem_wdata, 16'd0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed frames from the vector table.
        foreach (vt[k]) begin
            words.delete(); junk.delete();
            for (int i = 0; i < vt[k].n; i++) words.push_back(vt[k].w0 + 16'(i) * 16'h4444);
            for (int i = 0; i < vt[k].junk; i++) junk.push_back((i % 2) ? 8'hFF : 8'h00);
            send_frame(vt[k].a, vt[k].dlt);
            chk("vec_nwrites", wlog.size(), vt[k].n);
            if (wlog.size() > 0) begin
                chk("vec_first_addr", wlog[0].a, vt[k].exp_first);
                chk("vec_last_addr", wlog[wlog.size()-1].a, vt[k].exp_last);
            end
            @(negedge clk);
            chk("vec_done", done, vt[k].exp_done);
            chk("vec_err", err, vt[k].exp_err);
            chk("vec_hold", cpu_hold, vt[k].exp_hold);
            chk("vec_ready", s_ready, 1'b0);
            @(posedge clk); #1;
            clear = 1'b1; s_data = 8'hA5; s_valid = 1'b1;
            @(negedge clk);
            chk("clear_blocks_byte", s_ready, 1'b0);
            @(posedge clk); #1;
            clear = 1'b0; s_valid = 1'b0;
            @(negedge clk);
            chk("clear_done", done, 1'b0);
            chk("clear_err", err, 1'b0);
            chk("clear_idle_ready", s_ready, 1'b1);
            @(posedge clk); #1;
        end

        // Reset in the middle of a frame, right after D_L of the first word.
        wlog.delete();
        send_ok(8'hA5); send_ok(8'h00); send_ok(8'h20); send_ok(8'h00); send_ok(8'h02); send_ok(8'h34);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", s_ready, 1'b1);
        chk("midrst_addr", mem_addr, 11'd0);
        chk("midrst_wdata", mem_wdata, 16'd0);
        chk("midrst_hold", cpu_hold, 1'b1);
        chk("midrst_nwrites", wlog.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        words.delete(); junk.delete();
        words.push_back(16'hCAFE); words.push_back(16'hF00D);
        send_frame(16'h0020, 8'd0);
        check_frame("after_rst", 16'h0020, 1'b1);
        do_clear();

`ifdef BOOTLD_READBACK_EN
        // Corrupted readback on the first word stops the frame before the second word.
        flip_en = 1'b1;
        wlog.delete();
        send_ok(8'hA5); send_ok(8'h00); send_ok(8'h10); send_ok(8'h00); send_ok(8'h02);
        send_ok(8'h34); send_ok(8'h12);
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rb_err", err, 1'b1);
        chk("rb_done", done, 1'b0);
        chk("rb_hold", cpu_hold, 1'b1);
        chk("rb_nwrites", wlog.size(), 1);
        @(posedge clk); #1;
        send(8'h78, 5, acc);
        chk("rb_byte_refused", acc, 1'b0);
        flip_en = 1'b0;
        do_clear();
`endif

        // Randomized frames against the reference model.
        gaps = 1'b1;
        for (int f = 0; f < 20; f++) begin
            logic [15:0] a;
            logic [7:0]  dlt;
            int n;
            words.delete(); junk.delete();
            a   = 16'($urandom);
            if (f % 4 == 0) a[10:0] = 11'h7FE;
            n   = $urandom_range(0, 6);
            dlt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                junk.push_back(j);
            end
            send_frame(a, dlt);
            check_frame("rand", a, dlt == 8'd0);
            do_clear();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
